// File: rtl/booth_seq_multiply_pkg.sv
// Shared arithmetic definitions for the iterative multiply/divide units.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package cpu_arith_pkg;

    // Default operand width of the integer datapath.
    localparam int WIDTH_DEFAULT = 32;

    // Radix-4 Booth partial-product selection.
    typedef enum logic [2:0] {
        ZERO,
        PLUS_M,
        PLUS_2M,
        MINUS_M,
        MINUS_2M
    } booth_op_e;

    // Sequencer states of the multiplier.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } mul_state_e;

    // Map the window {Q[1], Q[0], q_m1} onto the Booth digit it encodes.
    function automatic booth_op_e booth_decode(input logic [2:0] win);
        booth_op_e op;
        case (win)
            3'b000, 3'b111: op = ZERO;
            3'b001, 3'b010: op = PLUS_M;
            3'b011:         op = PLUS_2M;
            3'b100:         op = MINUS_2M;
            default:        op = MINUS_M;   // 101, 110
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_seq_multiply_if.sv
// Request/response bundle between the control unit and the multiplier.
// Latency: n/a (wiring only).
// Backpressure: the requester must hold off new requests while busy is high.
interface booth_seq_multiply_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_hi;
    logic [WIDTH-1:0] product_lo;

    // Control unit side: issues operands, observes the result.
    modport master (
        output start,
        output multiplicand,
        output multiplier,
        input  busy,
        input  done,
        input  product_hi,
        input  product_lo
    );

    // Multiplier side.
    modport slave (
        input  start,
        input  multiplicand,
        input  multiplier,
        output busy,
        output done,
        output product_hi,
        output product_lo
    );

endinterface

// File: rtl/booth_seq_multiply_recode.sv
// Radix-4 Booth partial-product generator: selects 0, +/-M or +/-2M from a 3-bit window.
// Latency: combinational.
// Backpressure: none.
module booth_recode_r4
    import cpu_arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [2:0]       i_window,
    input  logic [WIDTH+1:0] i_m,       // multiplicand, already sign-extended by 2 bits
    output logic [WIDTH+1:0] o_addend
);

    booth_op_e        w_op;
    logic [WIDTH+1:0] w_m2;

    // 2M fits because i_m carries two guard bits above the operand.
    assign w_m2 = {i_m[WIDTH:0], 1'b0};

    // Select the addend for the current Booth digit.
    always_comb begin
        w_op     = booth_decode(i_window);
        o_addend = '0;
        case (w_op)
            PLUS_M:   o_addend = i_m;
            PLUS_2M:  o_addend = w_m2;
            MINUS_M:  o_addend = -i_m;
            MINUS_2M: o_addend = -w_m2;
            default:  o_addend = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_multiply.sv
// Sequential signed WIDTHxWIDTH multiplier, radix-4 Booth, 2 multiplier bits per clock.
// Latency: start sampled at edge 0, done pulse and product after edge WIDTH/2+1.
// Backpressure: busy high while iterating; start is ignored unless the unit is idle.
module booth_seq_multiply
    import cpu_arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT   // even and >= 4
) (
    input  logic               clk,
    input  logic               reset_n,
    booth_seq_multiply_if.slave bus
);

    localparam int             CW       = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
    localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH / 2 - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    mul_state_e       r_state;
    logic [WIDTH+1:0] r_m;       // sign-extended multiplicand
    logic [WIDTH+1:0] r_a;       // accumulator with 2 guard bits
    logic [WIDTH-1:0] r_q;       // multiplier, shifts out as product low half shifts in
    logic             r_qm1;     // bit shifted out below Q[0]
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_prod_hi;
    logic [WIDTH-1:0] r_prod_lo;

    logic [2:0]       w_window;
    logic [WIDTH+1:0] w_addend;
    logic [WIDTH+1:0] w_a_sum;
    logic [WIDTH+1:0] w_a_shift;
    logic [WIDTH-1:0] w_q_shift;

    assign w_window = {r_q[1:0], r_qm1};

    booth_recode_r4 #(
        .WIDTH (WIDTH)
    ) u_recode (
        .i_window (w_window),
        .i_m      (r_m),
        .o_addend (w_addend)
    );

    // Add the partial product, then arithmetic-shift {A,Q,q_m1} right by two.
    assign w_a_sum   = r_a + w_addend;
    assign w_a_shift = {{2{w_a_sum[WIDTH+1]}}, w_a_sum[WIDTH+1:2]};
    assign w_q_shift = {w_a_sum[1:0], r_q[WIDTH-1:2]};

    // Sequencer, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_m       <= '0;
            r_a       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_prod_hi <= '0;
            r_prod_lo <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                    if (bus.start) begin
                        r_m     <= {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
                        r_q     <= bus.multiplier;
                        r_a     <= '0;
                        r_qm1   <= 1'b0;
                        r_count <= CNT_INIT;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a   <= w_a_shift;
                    r_q   <= w_q_shift;
                    r_qm1 <= r_q[1];
                    if (r_count == '0) begin
                        // busy drops as the last iteration retires, so FINISH shows busy=0
                        r_busy  <= 1'b0;
                        r_state <= FINISH;
                    end else begin
                        r_count <= r_count - CNT_ONE;
                    end
                end
                FINISH: begin
                    // Low 2*WIDTH bits of {A,Q}; the guard bits are pure sign extension.
                    r_prod_hi <= r_a[WIDTH-1:0];
                    r_prod_lo <= r_q;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.product_hi = r_prod_hi;
    assign bus.product_lo = r_prod_lo;

endmodule

// File: tb/tb_booth_seq_multiply.sv
// Directed bench for booth_seq_multiply with hand-computed products.
// Latency: checks done exactly WIDTH/2+1 edges after the start edge.
// Backpressure: checks that start is ignored while busy and during FINISH.
module tb_booth_seq_multiply;

    logic clk;
    logic reset_n;

    int n_checks;
    int n_fail;
    int edge_k;     // edges since the start edge (start edge = 0)
    int busy_n;     // samples with busy high since the start edge
    int extra_done;

    booth_seq_multiply_if #(.WIDTH(32)) bif ();

    booth_seq_multiply #(
        .WIDTH (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        edge_k++;
        if (bif.busy) busy_n++;
    endtask

    // Issue one operation, wait (bounded) for done, and check timing and product.
    task automatic do_op(input logic [31:0] m, input logic [31:0] q,
                         input logic [31:0] eh, input logic [31:0] el, input string tag);
        bif.start        = 1'b1;
        bif.multiplicand = m;
        bif.multiplier   = q;
        edge_k = -1;
        busy_n = 0;
        step();
        bif.start = 1'b0;
        while (!bif.done && edge_k < 40) step();
        check({tag, " latency"}, 64'(edge_k), 64'd17);
        check({tag, " busy cycles"}, 64'(busy_n), 64'd16);
        check({tag, " hi"}, {32'd0, bif.product_hi}, {32'd0, eh});
        check({tag, " lo"}, {32'd0, bif.product_lo}, {32'd0, el});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        edge_k   = 0;
        busy_n   = 0;
        reset_n          = 1'b0;
        bif.start        = 1'b0;
        bif.multiplicand = '0;
        bif.multiplier   = '0;

        // Reset state
        #12;
        check("reset busy", {63'd0, bif.busy}, 64'd0);
        check("reset done", {63'd0, bif.done}, 64'd0);
        check("reset hi", {32'd0, bif.product_hi}, 64'd0);
        check("reset lo", {32'd0, bif.product_lo}, 64'd0);
        reset_n = 1'b1;
        #10;

        // Small signed: 7 * -3 = -21, plus busy/done edge placement
        bif.start        = 1'b1;
        bif.multiplicand = 32'd7;
        bif.multiplier   = 32'hFFFF_FFFD;
        edge_k = -1;
        busy_n = 0;
        step();
        bif.start = 1'b0;
        check("small busy after start", {63'd0, bif.busy}, 64'd1);
        while (edge_k < 15) step();
        check("small busy edge15", {63'd0, bif.busy}, 64'd1);
        check("small done edge15", {63'd0, bif.done}, 64'd0);
        step();
        check("small busy edge16", {63'd0, bif.busy}, 64'd0);
        check("small done edge16", {63'd0, bif.done}, 64'd0);
        step();
        check("small done edge17", {63'd0, bif.done}, 64'd1);
        check("small busy cycles", 64'(busy_n), 64'd16);
        check("small hi", {32'd0, bif.product_hi}, 64'h0000_0000_FFFF_FFFF);
        check("small lo", {32'd0, bif.product_lo}, 64'h0000_0000_FFFF_FFEB);
        step();
        check("small done drops", {63'd0, bif.done}, 64'd0);

        // Extremes and sign mix
        do_op(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "minxmin");
        do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, "maxxmax");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "minxneg1");
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "neg1xneg1");
        step();

        // Busy guard: start at cycle 4 and start during FINISH are both ignored
        bif.start        = 1'b1;
        bif.multiplicand = 32'd5;
        bif.multiplier   = 32'd6;
        edge_k = -1;
        busy_n = 0;
        step();
        bif.start = 1'b0;
        while (edge_k < 3) step();
        bif.start        = 1'b1;
        bif.multiplicand = 32'd9;
        bif.multiplier   = 32'd9;
        step();
        bif.start = 1'b0;
        while (!bif.done && edge_k < 16) step();
        check("guard busy in finish", {63'd0, bif.busy}, 64'd0);
        bif.start = 1'b1;
        step();
        bif.start = 1'b0;
        check("guard done edge17", {63'd0, bif.done}, 64'd1);
        check("guard hi", {32'd0, bif.product_hi}, 64'd0);
        check("guard lo", {32'd0, bif.product_lo}, 64'd30);
        extra_done = 0;
        repeat (10) begin
            step();
            if (bif.done) extra_done++;
        end
        check("guard no second done", 64'(extra_done), 64'd0);
        check("guard no new op", 64'(busy_n), 64'd16);
        check("guard hold lo", {32'd0, bif.product_lo}, 64'd30);
        check("guard hold hi", {32'd0, bif.product_hi}, 64'd0);

        // Reset mid-operation
        bif.start        = 1'b1;
        bif.multiplicand = 32'd3;
        bif.multiplier   = 32'd4;
        edge_k = -1;
        busy_n = 0;
        step();
        bif.start = 1'b0;
        while (edge_k < 7) step();
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst busy", {63'd0, bif.busy}, 64'd0);
        check("midrst done", {63'd0, bif.done}, 64'd0);
        check("midrst hi", {32'd0, bif.product_hi}, 64'd0);
        check("midrst lo", {32'd0, bif.product_lo}, 64'd0);
        step();
        step();
        reset_n = 1'b1;
        step();
        check("midrst no done", {63'd0, bif.done}, 64'd0);
        do_op(32'hFFFF_FFFE, 32'd8, 32'hFFFF_FFFF, 32'hFFFF_FFF0, "after reset");

        // Back-to-back: second start in the cycle after the done pulse
        step();
        do_op(32'd2, 32'd3, 32'h0000_0000, 32'h0000_0006, "b2b first");
        do_op(32'hFFFF_FFFC, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFEC, "b2b second");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
